input_conditioner: RTL and testbench
====================================

# input_conditioner

Parametrised multi-channel input conditioner: synchronises `WIDTH` asynchronous inputs into the `clk` domain, optionally debounces them, and reports per-channel edges selected by a runtime mode. It also generates a locally synchronised reset (async assert, sync deassert) for downstream logic. It sits directly behind the pads/external request lines and supersedes the single-bit synchroniser/edge-detect register.

## Interface
Parameters:
- `WIDTH`, 8, number of independent input channels (≥1).
- `SYNC_STAGES`, 2, synchroniser flop depth per channel (≥2).
- `DEBOUNCE_CNT`, 16, consecutive stable cycles required before a level change is accepted (≥1; used only with debounce compiled in).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_i`  in  WIDTH  asynchronous raw inputs.
- `edge_mode_i`  in  2  edge select, all channels: 00 none, 01 rising, 10 falling, 11 both.
- `rst_sync_o`  out  1  synchronised reset, active-low, async assert / sync deassert.
- `level_o`  out  WIDTH  conditioned (synchronised, optionally debounced) level.
- `edge_o`  out  WIDTH  one-cycle pulse per accepted level change matching `edge_mode_i`.
- `edge_any_o`  out  1  registered OR of the same-cycle `edge_o` bits (high in the same cycle as any `edge_o` bit).

## Operation
- Reset synchroniser: 2 flops, both cleared asynchronously by `rst` low, shift in constant 1. `rst_sync_o` = second flop. All other state is asynchronously cleared by `rst_sync_o` low.
- Reset values: `rst_sync_o`=0, `level_o`=0, `edge_o`=0, `edge_any_o`=0, debounce counters=0, synchroniser flops=0.
- Per channel: `data_i[i]` passes through `SYNC_STAGES` flops -> `s[i]`.
- Level update (no debounce): `level_o[i]` <= `s[i]` every cycle.
- Edge: on the same edge that `level_o[i]` changes, `edge_o[i]` <= 1 if (0->1 and mode bit0) or (1->0 and mode bit1), else 0. `edge_o` is never high two consecutive cycles for the same transition.
- `edge_mode_i` is sampled at the update edge; a change takes effect on the next edge, with no retroactive pulses.
- After reset release with an input held high, `level_o` rises after normal latency and a rising edge is reported if enabled.

## Timing
- `rst` low -> `rst_sync_o`, `level_o`, `edge_o`, `edge_any_o` low immediately (asynchronous).
- `rst` rises before edge k -> `rst_sync_o` high after edge k+1. Conditioning logic runs from edge k+2.
- No debounce: `data_i` stable from before edge 1 -> `s` updates at edge `SYNC_STAGES`, `level_o`/`edge_o` at edge `SYNC_STAGES`+1. Latency is `SYNC_STAGES`+1 cycles.
- `edge_o` and `edge_any_o` are high exactly one cycle per accepted transition.
- `rst` asserted mid-debounce: counter and level are cleared; no edge is reported.

## Configuration
- `INPUT_COND_DEBOUNCE_EN` defined: per-channel counter of width clog2(`DEBOUNCE_CNT`). Behaviour each edge:
  - If `s[i]` != `level_o[i]`: if cnt == `DEBOUNCE_CNT`-1, `level_o[i]`<=`s[i]` and cnt<=0; else cnt++.
  - If `s[i]` == `level_o[i]`: cnt<=0.
  - Latency `SYNC_STAGES`+`DEBOUNCE_CNT`. A glitch shorter than `DEBOUNCE_CNT` cycles at `s` produces no level change and no edge. `DEBOUNCE_CNT`=1 gives the same timing as no debounce.
- Not defined: no counters; `DEBOUNCE_CNT` is ignored; level follows `s` with one-cycle latency.

## Structure
- Shared package `input_cond_pkg`:
  - `edge_mode_t` enum: `EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`.
  - Constant `RST_SYNC_STAGES`=2.
- Sub-module `sync_chain` (parameter `STAGES`, 1-bit, async active-low clear): instantiated per channel, and reused for the reset synchroniser with input tied high.
- Top holds the debounce counters, level/edge registers and the OR reduction.

## Test plan
- Reset: `rst`=0 with `data_i`=8'hFF -> all outputs 0. Release `rst` -> `rst_sync_o`=1 two edges later. `level_o`=8'hFF after `SYNC_STAGES`+1 (or +`DEBOUNCE_CNT`) more edges. With mode 01, single `edge_o`=8'hFF pulse and `edge_any_o`=1 for one cycle.
- Mode sweep, no debounce, channel 0 toggling 0->1->0: mode 00 gives no pulses; 01 gives one pulse on the rise; 10 gives one pulse on the fall; 11 gives two pulses, each `SYNC_STAGES`+1 cycles after the input change.
- Debounce on, `DEBOUNCE_CNT`=16: 15-cycle high glitch on bit 3 -> `level_o[3]` stays 0, no edge. A 16-cycle high on bit 3 -> `level_o[3]`=1 at edge `SYNC_STAGES`+16 with one `edge_o[3]` pulse.
- Simultaneous events: bits 0 and 7 rise in the same cycle, mode 11 -> `edge_o`=8'h81 for one cycle, `edge_any_o`=1 once.
- Reset mid-operation: assert `rst` 10 cycles into a debounce run -> counter and outputs cleared. After release, the held-high input reports exactly one full debounce period later.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared types and constants for the input conditioner slice.
// Optional debounce is enabled by defining INPUT_COND_DEBOUNCE_EN.
package input_cond_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   localparam int RST_SYNC_STAGES = 2;

   // Counter width that stays legal when only a single stable cycle is needed.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
// Used for data channels and, with its input tied high, for reset release.
module sync_chain
   import input_cond_pkg::*;
#(
   parameter int STAGES = RST_SYNC_STAGES
) (
   input  logic clk,
   input  logic clr_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb chain_d = {chain_q[STAGES-2:0], d_i};

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) chain_q <= '0;
      else        chain_q <= chain_d;
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchroniser / optional debouncer / edge reporter with local reset synchroniser.
// Debounce counters are built only when INPUT_COND_DEBOUNCE_EN is defined.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       edge_mode_i,
   output logic             rst_sync_o,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] edge_o,
   output logic             edge_any_o
);

   if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CNT < 1) begin : g_param_check
      $error("input_conditioner: illegal parameter value");
   end

   logic rst_sync_n;

   sync_chain #(.STAGES(RST_SYNC_STAGES)) u_rst_sync (
      .clk   (clk),
      .clr_n (rst),
      .d_i   (1'b1),
      .q_o   (rst_sync_n)
   );

   logic [WIDTH-1:0] s;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .clr_n (rst_sync_n),
         .d_i   (data_i[gi]),
         .q_o   (s[gi])
      );
   end

   edge_mode_t       mode;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] rise, fall;
   logic             edge_any_q, edge_any_d;

   assign mode = edge_mode_t'(edge_mode_i);

`ifdef INPUT_COND_DEBOUNCE_EN
   localparam int            CW       = cnt_width(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

   logic [CW-1:0] cnt_q [WIDTH];
   logic [CW-1:0] cnt_d [WIDTH];

   // A channel accepts a new level only after DEBOUNCE_CNT consecutive disagreeing samples.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) level_d[i] = s[i];
            else                      cnt_d[i]   = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   always_comb level_d = s;
`endif

   always_comb begin
      rise   = level_d & ~level_q;
      fall   = level_q & ~level_d;
      edge_d = '0;
      unique case (mode)
         EDGE_RISE: edge_d = rise;
         EDGE_FALL: edge_d = fall;
         EDGE_BOTH: edge_d = rise | fall;
         default:   edge_d = '0;
      endcase
      edge_any_d = |edge_d;
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         level_q    <= '0;
         edge_q     <= '0;
         edge_any_q <= 1'b0;
      end else begin
         level_q    <= level_d;
         edge_q     <= edge_d;
         edge_any_q <= edge_any_d;
      end
   end

   assign rst_sync_o = rst_sync_n;
   assign level_o    = level_q;
   assign edge_o     = edge_q;
   assign edge_any_o = edge_any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed table, corner sequences and random traffic vs a window-based model.
`timescale 1ns/1ps
module tb_input_conditioner;

   localparam int W = 8;
   localparam int S = 2;
   localparam int D = 16;
`ifdef INPUT_COND_DEBOUNCE_EN
   localparam int DEB = D;
`else
   localparam int DEB = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] data_i = '0;
   logic [1:0]   edge_mode_i = 2'b00;
   logic         rst_sync_o;
   logic [W-1:0] level_o;
   logic [W-1:0] edge_o;
   logic         edge_any_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   input_conditioner #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CNT(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_i      (data_i),
      .edge_mode_i (edge_mode_i),
      .rst_sync_o  (rst_sync_o),
      .level_o     (level_o),
      .edge_o      (edge_o),
      .edge_any_o  (edge_any_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: s is the input delayed by S samples; a level is accepted
   // once the last DEB samples of s all agree and differ from the current level.
   int unsigned  m_rel;
   bit           m_rsync;
   logic [W-1:0] m_level, m_edge;
   bit           m_any;
   logic [W-1:0] dq[$];
   logic [W-1:0] sq[$];

   task automatic model_clear();
      m_rel = 0; m_rsync = 0; m_level = '0; m_edge = '0; m_any = 0;
      dq.delete(); sq.delete();
   endtask

   initial model_clear();
   always @(negedge rst) model_clear();

   always @(posedge clk) begin
      logic [W-1:0] s_pre, new_level, rises, falls;
      bit same;
      if (rst) begin
         if (m_rsync) begin
            s_pre = (dq.size() >= S) ? dq[dq.size() - S] : '0;
            dq.push_back(data_i);
            if (dq.size() > S) void'(dq.pop_front());
            sq.push_back(s_pre);
            if (sq.size() > DEB) void'(sq.pop_front());
            new_level = m_level;
            if (sq.size() == DEB) begin
               for (int i = 0; i < W; i++) begin
                  same = 1;
                  for (int j = 1; j < sq.size(); j++)
                     if (sq[j][i] != sq[0][i]) same = 0;
                  if (same && sq[0][i] != m_level[i]) new_level[i] = sq[0][i];
               end
            end
            rises   = new_level & ~m_level;
            falls   = m_level & ~new_level;
            m_edge  = (edge_mode_i[0] ? rises : '0) | (edge_mode_i[1] ? falls : '0);
            m_any   = |m_edge;
            m_level = new_level;
         end
         m_rel++;
         m_rsync = (m_rel >= 2);
      end
   end

   always @(posedge clk) begin
      #1;
      chk("rst_sync_o", {31'b0, rst_sync_o}, {31'b0, m_rsync});
      chk("level_o", {24'b0, level_o}, {24'b0, m_level});
      chk("edge_o", {24'b0, edge_o}, {24'b0, m_edge});
      chk("edge_any_o", {31'b0, edge_any_o}, {31'b0, m_any});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [1:0]   mode;
      logic [W-1:0] data;
      logic [W-1:0] exp_level;
      int           exp_pulses;
      logic [W-1:0] exp_edge;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, p, hi, first, g, steps;
      logic [W-1:0] seen;

      vecs[0]  = '{2'b00, 8'h00, 8'h00, 0, 8'h00};
      vecs[1]  = '{2'b00, 8'h01, 8'h01, 0, 8'h00};
      vecs[2]  = '{2'b00, 8'h00, 8'h00, 0, 8'h00};
      vecs[3]  = '{2'b01, 8'h01, 8'h01, 1, 8'h01};
      vecs[4]  = '{2'b01, 8'h00, 8'h00, 0, 8'h00};
      vecs[5]  = '{2'b10, 8'h01, 8'h01, 0, 8'h00};
      vecs[6]  = '{2'b10, 8'h00, 8'h00, 1, 8'h01};
      vecs[7]  = '{2'b11, 8'h01, 8'h01, 1, 8'h01};
      vecs[8]  = '{2'b11, 8'h00, 8'h00, 1, 8'h01};
      vecs[9]  = '{2'b11, 8'h81, 8'h81, 1, 8'h81};
      vecs[10] = '{2'b11, 8'h00, 8'h00, 1, 8'h81};
      vecs[11] = '{2'b10, 8'h3C, 8'h3C, 0, 8'h00};
      vecs[12] = '{2'b10, 8'hC3, 8'hC3, 1, 8'h3C};
      vecs[13] = '{2'b01, 8'h00, 8'h00, 0, 8'h00};

      // Reset with inputs held high, then release.
      rst = 1'b0; data_i = 8'hFF; edge_mode_i = 2'b01;
      repeat (3) step();
      chk("reset rst_sync_o", {31'b0, rst_sync_o}, 0);
      chk("reset level_o", {24'b0, level_o}, 0);
      chk("reset edge_o", {24'b0, edge_o}, 0);
      chk("reset edge_any_o", {31'b0, edge_any_o}, 0);
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         step(); n++;
         if (rst_sync_o) break;
      end
      chk("rst_sync release latency", n, 2);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         step(); n++;
         if (level_o == 8'hFF) break;
      end
      chk("post-reset level latency", n, S + DEB);
      chk("post-reset edge_o", {24'b0, edge_o}, 32'hFF);
      chk("post-reset edge_any_o", {31'b0, edge_any_o}, 1);
      step();
      chk("post-reset edge_o cleared", {24'b0, edge_o}, 0);
      chk("post-reset edge_any_o cleared", {31'b0, edge_any_o}, 0);
      repeat (2) step();

      // Directed table: mode sweep and simultaneous channels.
      for (int v = 0; v < 14; v++) begin
         edge_mode_i = vecs[v].mode;
         data_i      = vecs[v].data;
         p = 0; seen = '0; first = 0;
         for (int c = 1; c <= S + DEB + 3; c++) begin
            step();
            if (edge_any_o) begin
               p++;
               if (first == 0) first = c;
            end
            seen |= edge_o;
         end
         chk($sformatf("vec%0d level", v), {24'b0, level_o}, {24'b0, vecs[v].exp_level});
         chk($sformatf("vec%0d pulses", v), p, vecs[v].exp_pulses);
         chk($sformatf("vec%0d edge bits", v), {24'b0, seen}, {24'b0, vecs[v].exp_edge});
         if (vecs[v].exp_pulses > 0)
            chk($sformatf("vec%0d edge latency", v), first, S + DEB);
      end

      // Short glitch on bit 3: rejected when debouncing, passed through otherwise.
      edge_mode_i = 2'b01;
      g = (DEB > 1) ? DEB - 1 : 1;
      p = 0; hi = 0;
      for (int c = 0; c < g + S + DEB + 4; c++) begin
         data_i = (c < g) ? 8'h08 : 8'h00;
         step();
         if (edge_o[3]) p++;
         if (level_o[3]) hi++;
      end
      chk("glitch pulses", p, (DEB == 1) ? 1 : 0);
      chk("glitch level cycles", hi, (DEB == 1) ? 1 : 0);

      // Pulse exactly DEB long on bit 3: accepted with one rising edge.
      p = 0; hi = 0; first = 0;
      for (int c = 0; c < 2 * DEB + S + 4; c++) begin
         data_i = (c < DEB) ? 8'h08 : 8'h00;
         step();
         if (edge_o[3]) begin
            p++;
            if (first == 0) first = c + 1;
         end
         if (level_o[3]) hi++;
      end
      chk("full pulse edges", p, 1);
      chk("full pulse edge latency", first, S + DEB);
      chk("full pulse level cycles", hi, DEB);

      // Reset in the middle of a debounce run.
      data_i = 8'h08;
      repeat (10) step();
      rst = 1'b0;
      #1;
      chk("mid reset rst_sync_o", {31'b0, rst_sync_o}, 0);
      chk("mid reset level_o", {24'b0, level_o}, 0);
      chk("mid reset edge_o", {24'b0, edge_o}, 0);
      chk("mid reset edge_any_o", {31'b0, edge_any_o}, 0);
      repeat (2) step();
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         step(); n++;
         if (level_o[3]) break;
      end
      chk("mid reset recovery latency", n, S + DEB + 2);
      chk("mid reset recovery edge_o", {24'b0, edge_o}, 32'h08);
      data_i = 8'h00;
      repeat (S + DEB + 2) step();

      // Random traffic against the model.
      steps = 0;
      while (steps < 4000) begin
         data_i = W'($urandom);
         if ($urandom_range(0, 9) == 0) edge_mode_i = 2'($urandom);
         if ($urandom_range(0, 60) == 0) begin
            rst = 1'b0;
            repeat ($urandom_range(1, 3)) begin step(); steps++; end
            rst = 1'b1;
         end
         n = $urandom_range(1, 2 * DEB + 4);
         repeat (n) begin step(); steps++; end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
